timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 135 +++++++++++++
 tb/tb_timer_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Debounced push-button countdown timer: IDLE -> RUN <-> PAUSE -> DONE.
// One countdown tick every TICK_DIV cycles of RUN; done pulses once on entry to DONE.
`timescale 1ns/1ps
module timer_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TICK_DIV     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       busy,
  output logic       done,
  output logic       led
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] STAB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]    PRESC_LAST = 8'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  logic          r_sync1, r_sync2;
  logic [1:0]    r_ok;
  logic          r_level, r_level_q;
  logic [CW-1:0] r_stab_cnt;
  logic          r_armed;
  logic          w_press;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_count, w_count_nxt;
  logic [7:0]    r_presc, w_presc_nxt;
  logic          r_done, w_done_nxt;
  logic          w_tick;

  // Presses only count once the synchronizer has shown the button low after reset,
  // so a button held through reset release cannot start the timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_ok       <= 2'b00;
      r_level    <= 1'b0;
      r_level_q  <= 1'b0;
      r_stab_cnt <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_sync1   <= button;
      r_sync2   <= r_sync1;
      r_ok      <= {r_ok[0], 1'b1};
      r_level_q <= r_level;
      if (r_sync2 != r_level) begin
        if (r_stab_cnt == STAB_LAST) begin
          r_level    <= r_sync2;
          r_stab_cnt <= '0;
        end else begin
          r_stab_cnt <= r_stab_cnt + 1'b1;
        end
      end else begin
        r_stab_cnt <= '0;
      end
      if (r_ok[1] && !r_sync2 && !r_level) r_armed <= 1'b1;
    end
  end

  assign w_press = r_level & ~r_level_q & r_armed;
  assign w_tick  = (r_presc == PRESC_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_count_nxt = load_val;
          w_presc_nxt = 8'd0;
          w_state_nxt = (load_val != 8'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (r_count == 8'd0) begin
          w_state_nxt = S_DONE;
        end else if (w_tick) begin
          // A terminal tick takes priority over a simultaneous press.
          w_presc_nxt = 8'd0;
          w_count_nxt = r_count - 8'd1;
          if (r_count == 8'd1)  w_state_nxt = S_DONE;
          else if (w_press)     w_state_nxt = S_PAUSE;
        end else if (w_press) begin
          w_state_nxt = S_PAUSE;
        end else begin
          w_presc_nxt = r_presc + 8'd1;
        end
      end
      S_PAUSE: begin
        if (w_press) w_state_nxt = S_RUN;
      end
      S_DONE: begin
        w_count_nxt = 8'd0;
        if (w_press) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_done_nxt = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= 8'd0;
      r_presc <= 8'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign busy  = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign led   = (r_state == S_DONE);
  assign done  = r_done;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with literal expectations plus a randomized
// run, all continuously compared against a remaining-cycles reference model.
`timescale 1ns/1ps
module tb_timer_ctrl;
  localparam int DEB = 4;
  localparam int TD  = 5;
  localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_PAUSE = 2'd2, M_DONE = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [7:0] count;
  logic       busy, done, led;

  int errors = 0;
  int checks = 0;

  timer_ctrl #(.DEBOUNCE_CYC(DEB), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .button(button), .load_val(load_val),
    .count(count), .busy(busy), .done(done), .led(led)
  );

  always #10 clk = ~clk;

  // Model: button history for debouncing, and the countdown as a number of
  // remaining RUN cycles; count is that number rounded up to whole ticks.
  typedef struct packed {
    logic           s1;
    logic           s2;
    logic [DEB-1:0] hist;
    logic           level;
    logic           armed;
    logic [1:0]     ncyc;
    logic           pend;
    logic [1:0]     mode;
    logic [10:0]    left;
    logic           done;
  } m_t;

  m_t m = '0;

  function automatic m_t step(input m_t c, input logic b, input logic [7:0] lv);
    m_t n;
    logic press;
    logic [DEB-1:0] h;
    n = c;
    press = c.pend;
    h = {c.hist[DEB-2:0], c.s2};
    n.s1 = b;
    n.s2 = c.s1;
    n.hist = h;
    n.armed = c.armed | ((c.ncyc >= 2'd2) && !c.s2 && !c.level);
    n.ncyc = (c.ncyc == 2'd3) ? 2'd3 : c.ncyc + 2'd1;
    n.level = (h == {DEB{~c.level}}) ? ~c.level : c.level;
    n.pend = !c.level && n.level && c.armed;
    n.done = 1'b0;
    case (c.mode)
      M_IDLE: if (press) begin
        n.left = 11'(int'(lv) * TD);
        if (lv == 8'd0) begin n.mode = M_DONE; n.done = 1'b1; end
        else n.mode = M_RUN;
      end
      M_RUN: begin
        if (press && ((int'(c.left) % TD) != 1)) n.mode = M_PAUSE;
        else begin
          n.left = c.left - 11'd1;
          if (n.left == 11'd0) begin n.mode = M_DONE; n.done = 1'b1; end
          else if (press) n.mode = M_PAUSE;
        end
      end
      M_PAUSE: if (press) n.mode = M_RUN;
      default: if (press) n.mode = M_IDLE;
    endcase
    return n;
  endfunction

  function automatic int m_count(input m_t s);
    return (int'(s.left) + TD - 1) / TD;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= step(m, button, load_val);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_count", int'(count), m_count(m));
    chk("model_busy", int'(busy), int'(m.mode == M_RUN || m.mode == M_PAUSE));
    chk("model_done", int'(done), int'(m.done));
    chk("model_led", int'(led), int'(m.mode == M_DONE));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic press(input int hold);
    button = 1'b1;
    tick(hold);
    button = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_led"}, int'(led), 0);
    chk({name, "_count"}, int'(count), 0);
  endtask

  initial begin
    int busy_n, done_n, k;
    bit found, busy_seen;

    // Reset behaviour
    tick(5);
    chk_idle("in_reset");
    chk("in_reset_done", int'(done), 0);
    rst = 1'b1;
    tick(10);
    chk_idle("after_reset");

    // Clean press, load 3: 15 RUN cycles, count 3,2,1 at 5-cycle steps
    load_val = 8'd3;
    button = 1'b1;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) button = 1'b0;
      tick(1);
      if (busy) begin
        if (busy_n % 5 == 0) chk("run_count", int'(count), 3 - busy_n / 5);
        busy_n++;
      end
      if (done) done_n++;
    end
    chk("run_cycles", busy_n, 15);
    chk("done_pulses", done_n, 1);
    chk("done_led", int'(led), 1);
    chk("done_busy", int'(busy), 0);
    chk("done_count", int'(count), 0);
    press(6);
    tick(10);
    chk_idle("done_to_idle");

    // Short glitches are rejected
    for (int g = 1; g <= 3; g++) begin
      button = 1'b1;
      tick(g);
      button = 1'b0;
      tick(12);
      chk_idle("glitch");
    end

    // Pause after 7 RUN cycles (13 left -> count 3), resume, 13 more to DONE
    load_val = 8'd4;
    press(4);
    tick(4);
    press(4);
    tick(3);
    chk("pause_count", int'(count), 3);
    chk("pause_busy", int'(busy), 1);
    tick(30);
    chk("pause_hold_count", int'(count), 3);
    chk("pause_hold_busy", int'(busy), 1);
    chk("pause_hold_led", int'(led), 0);
    button = 1'b1;
    k = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (i == 4) button = 1'b0;
      tick(1);
      k++;
      if (led) found = 1;
    end
    button = 1'b0;
    chk("resume_to_done_cycles", k, 7 + 13);
    chk("resume_done_count", int'(count), 0);
    press(6);
    tick(10);
    chk_idle("pause_case_idle");

    // Zero load goes straight to DONE
    load_val = 8'd0;
    button = 1'b1;
    busy_seen = 0;
    done_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) button = 1'b0;
      tick(1);
      if (busy) busy_seen = 1;
      if (done) done_n++;
    end
    chk("zero_busy_seen", int'(busy_seen), 0);
    chk("zero_done_pulses", done_n, 1);
    chk("zero_led", int'(led), 1);
    press(6);
    tick(10);
    chk_idle("zero_idle");

    // Asynchronous reset in RUN with count=2
    load_val = 8'd3;
    press(4);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (count == 8'd2) found = 1;
    end
    chk("reach_count2", int'(found), 1);
    rst = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_done", int'(done), 0);
    tick(3);
    rst = 1'b1;
    tick(20);
    chk_idle("post_reset_idle");

    // Button held through reset release gives no press
    rst = 1'b0;
    button = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(25);
    chk_idle("held_button");
    button = 1'b0;
    tick(10);
    chk_idle("held_released");
    load_val = 8'd2;
    press(5);
    tick(3);
    chk("held_then_press_busy", int'(busy), 1);
    tick(20);

    // Randomized traffic, checked by the model every cycle
    for (int seg = 0; seg < 150; seg++) begin
      int r;
      r = int'($urandom_range(0, 19));
      load_val = 8'($urandom_range(0, 6));
      if (r == 0) begin
        rst = 1'b0;
        tick(int'($urandom_range(1, 3)));
        rst = 1'b1;
      end else if (r < 3) begin
        button = 1'b1;
        tick(int'($urandom_range(1, 3)));
        button = 1'b0;
        tick(int'($urandom_range(2, 10)));
      end else if (r == 3) begin
        for (int i = 0; i < 10; i++) begin
          button = 1'($urandom_range(0, 1));
          tick(1);
        end
        button = 1'b0;
        tick(int'($urandom_range(4, 20)));
      end else begin
        button = 1'b1;
        tick(int'($urandom_range(4, 12)));
        button = 1'b0;
        tick(int'($urandom_range(4, 40)));
      end
    end
    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
